// File: rtl/nios_sd_loader_cpu_cpu_ocimem_arbiter.sv
// nios_sd_loader_cpu_cpu_ocimem_arbiter
// Shares the CPU's single-port OCI debug RAM between JTAG system-clock
// actions and the Avalon debug-memory slave.
//   clk, reset_n            : system clock, asynchronous active-low reset
//   jdo, take_*_ocimem_*    : JTAG payload and single-cycle action pulses
//   av_*, debugaccess       : Avalon slave (held commands, waitrequest stall)
//   ram_*                   : synchronous RAM port (read data one cycle later)
//   MonDReg, jtag_rd_done   : JTAG read data and its update pulse
//   jtag_overrun            : sticky, a pulse replaced an unstarted JTAG op
module nios_sd_loader_cpu_cpu_ocimem_arbiter #(
  parameter int unsigned ADDR_W = 8
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [37:0]       jdo,
  input  logic              take_action_ocimem_a,
  input  logic              take_no_action_ocimem_a,
  input  logic              take_action_ocimem_b,
  input  logic [ADDR_W-1:0] av_address,
  input  logic              av_read,
  input  logic              av_write,
  input  logic [31:0]       av_writedata,
  input  logic [3:0]        av_byteenable,
  input  logic              debugaccess,
  output logic [31:0]       av_readdata,
  output logic              av_waitrequest,
  output logic [ADDR_W-1:0] ram_addr,
  output logic              ram_wr,
  output logic [31:0]       ram_wdata,
  output logic [3:0]        ram_be,
  input  logic [31:0]       ram_rdata,
  output logic [31:0]       MonDReg,
  output logic              jtag_rd_done,
  output logic              jtag_overrun
);

  typedef enum logic [2:0] {IDLE, J_RA, J_RD, J_WR, A_RA, A_RD, A_WR} state_t;

  state_t            state, state_nx;
  logic [ADDR_W-1:0] jdo_addr;
  logic [ADDR_W-1:0] jaddr;
  logic              jaddr_loaded;
  logic              new_rd, new_wr, new_op;
  logic              j_pend, j_is_wr;
  logic [31:0]       j_data;
  logic              last_jtag;
  logic              a_req_q, a_req, a_busy, a_dbg;
  logic              grant_j, grant_a;
  logic              unused_jdo;

  assign jdo_addr   = jdo[17+ADDR_W-1:17];
  assign unused_jdo = &{1'b0, jdo[37:36], jdo[2:0]};

  assign new_wr = take_action_ocimem_b;
  assign new_rd = ~new_wr & (take_no_action_ocimem_a | (take_action_ocimem_a & jdo[34]));
  assign new_op = new_rd | new_wr;

  // Avalon commands are registered before arbitration so both sides see
  // the same one-cycle request latency; the registered copy is cleared when
  // the command completes so a held command is not served twice.
  assign a_busy = (state == A_RD) || (state == A_WR);
  assign a_req  = a_req_q & (av_read | av_write);

  always_comb begin
    state_nx = state;
    grant_j  = 1'b0;
    grant_a  = 1'b0;
    case (state)
      IDLE: begin
        // JTAG by default; after a JTAG op a waiting Avalon request goes next.
        if (j_pend && !(a_req && last_jtag)) begin
          grant_j  = 1'b1;
          state_nx = j_is_wr ? J_WR : J_RA;
        end else if (a_req) begin
          grant_a  = 1'b1;
          state_nx = av_write ? A_WR : A_RA;
        end
      end
      J_RA:    state_nx = J_RD;
      A_RA:    state_nx = A_RD;
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    av_waitrequest = ~a_busy;
    av_readdata    = ((state == A_RD) && a_dbg) ? ram_rdata : '0;
    ram_wr         = (state == J_WR) || ((state == A_WR) && a_dbg);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nx;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ram_addr     <= '0;
      ram_wdata    <= '0;
      ram_be       <= '0;
      a_dbg        <= 1'b0;
      a_req_q      <= 1'b0;
      last_jtag    <= 1'b0;
      j_pend       <= 1'b0;
      j_is_wr      <= 1'b0;
      j_data       <= '0;
      jaddr        <= '0;
      jaddr_loaded <= 1'b0;
      MonDReg      <= '0;
      jtag_rd_done <= 1'b0;
      jtag_overrun <= 1'b0;
    end else begin
      a_req_q <= (av_read | av_write) & ~a_busy & ~grant_a;

      if (grant_j) begin
        ram_addr  <= jaddr;
        ram_wdata <= j_data;
        ram_be    <= 4'hF;
        last_jtag <= 1'b1;
      end else if (grant_a) begin
        ram_addr  <= av_address;
        ram_wdata <= av_writedata;
        ram_be    <= av_write ? av_byteenable : 4'hF;
        a_dbg     <= debugaccess;
        last_jtag <= 1'b0;
      end

      // A new pulse always overwrites the pending slot; consuming it at the
      // same edge still leaves the new one pending.
      if (new_op) begin
        j_pend  <= 1'b1;
        j_is_wr <= new_wr;
        j_data  <= jdo[34:3];
      end else if (grant_j) begin
        j_pend  <= 1'b0;
      end

      if (take_action_ocimem_a && jdo[35])
        jtag_overrun <= 1'b0;
      else if (new_op && j_pend && !grant_j)
        jtag_overrun <= 1'b1;

      // The op's address is taken from jaddr at grant. A load that arrives
      // while an op is in flight must not be bumped by that op's completion.
      if (take_action_ocimem_a)
        jaddr_loaded <= 1'b1;
      else if (grant_j)
        jaddr_loaded <= 1'b0;

      if (take_action_ocimem_a)
        jaddr <= jdo_addr;
      else if (((state == J_RD) || (state == J_WR)) && !jaddr_loaded)
        jaddr <= ram_addr + ADDR_W'(1);

      jtag_rd_done <= (state == J_RD);
      if (state == J_RD) MonDReg <= ram_rdata;
    end
  end

endmodule
